i2c_master_ctrl: RTL

Single-byte I2C bus master that generates SCL and SDA as open-drain enables from the system clock. Each transaction issues START, a 7-bit address plus R/W bit, one data byte (written, or read with master NACK), then STOP. It sits directly upstream of the I2C slave under test and drives the shared `scl`/`sda` wires through open-drain enables. It replaces the bench-level clock divider and `sda_out` muxing with synthesizable RTL.

---
 rtl/i2c_pkg.sv | 33 +++
 rtl/i2c_qtr_timer.sv | 59 +++++
 rtl/i2c_master_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared types and constants for the single-byte I2C master.
//   i2c_mst_state_e : transaction phase of the master FSM
//   i2c_qtr_e       : quarter of an SCL bit period (Q0..Q3)
//   I2C_BIT_QTRS    : quarters per bit time
//   I2C_ADDR_W      : slave address width
// ---------------------------------------------------------------------------
package i2c_pkg;

    localparam int I2C_BIT_QTRS = 4;
    localparam int I2C_ADDR_W   = 7;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_MNACK,
        ST_STOP
    } i2c_mst_state_e;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } i2c_qtr_e;

endpackage

// File: rtl/i2c_qtr_timer.sv
// ---------------------------------------------------------------------------
// i2c_qtr_timer
// Divides the system clock into SCL quarter periods of QTR cycles each.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   clear      : forces count 0 / quarter Q0 (held while the master idles)
//   hold       : freezes the count (slave clock stretching)
//   tick       : high on the last cycle of the current quarter
//   qtr        : index of the current quarter
// ---------------------------------------------------------------------------
module i2c_qtr_timer
    import i2c_pkg::*;
#(
    parameter int QTR = 250
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     clear,
    input  logic     hold,
    output logic     tick,
    output i2c_qtr_e qtr
);

    localparam int            CW      = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(QTR - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    i2c_qtr_e      qtr_q, qtr_d;

    assign tick = !clear && !hold && (cnt_q == CNT_MAX);
    assign qtr  = qtr_q;

    // The quarter index wraps Q3 -> Q0 naturally in two bits, so bit
    // boundaries need no separate counter.
    always_comb begin
        cnt_d = cnt_q;
        qtr_d = qtr_q;
        if (clear) begin
            cnt_d = '0;
            qtr_d = Q0;
        end else if (tick) begin
            cnt_d = '0;
            qtr_d = i2c_qtr_e'(qtr_q + 2'd1);
        end else if (!hold) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            qtr_q <= Q0;
        end else begin
            cnt_q <= cnt_d;
            qtr_q <= qtr_d;
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_master_ctrl
// Single-byte I2C master: START, 7-bit address + R/W, one data byte
// (write, or read finished with a master NACK), STOP. SCL and SDA are
// driven as open-drain pull-low enables.
// Ports:
//   clk, reset        : system clock, synchronous active-high reset
//   start             : one-cycle request, accepted only while busy=0
//   addr, rw          : slave address and direction (1 = read), latched
//   data_write        : byte to write, latched on accepted start
//   data_read         : byte received by the last read
//   busy, done        : transaction in progress / one-cycle completion
//   ack_err           : a slave ACK bit was sampled high
//   scl_oe, sda_oe    : 1 pulls the line low
//   scl_i, sda_i      : line levels
// Optional feature macro: I2C_CLK_STRETCH_EN -- when defined, the Q2
// quarter is extended while scl_i is still low (slave clock stretching).
// ---------------------------------------------------------------------------
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int HALF_PERIOD = 500
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [I2C_ADDR_W-1:0] addr,
    input  logic                  rw,
    input  logic [7:0]            data_write,
    output logic [7:0]            data_read,
    output logic                  busy,
    output logic                  done,
    output logic                  ack_err,
    output logic                  scl_oe,
    output logic                  sda_oe,
    input  logic                  scl_i,
    input  logic                  sda_i
);

    localparam int QTR = HALF_PERIOD / 2;

    i2c_mst_state_e        state_q, state_d;
    logic [I2C_ADDR_W-1:0] addr_q, addr_d;
    logic                  rw_q, rw_d;
    logic [7:0]            wdata_q, wdata_d;
    logic [7:0]            rx_q, rx_d;
    logic [7:0]            data_read_q, data_read_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ack_err_q, ack_err_d;
    logic                  scl_oe_q, scl_oe_d;
    logic                  sda_oe_q, sda_oe_d;

    logic     tick;
    logic     hold;
    i2c_qtr_e qtr;
    i2c_qtr_e qtr_nxt;
    logic     bit_end;
    logic     sample;
    logic     low_half;
    logic [7:0] tx_byte;

`ifdef I2C_CLK_STRETCH_EN
    // Only the SCL-high quarter waits for the line to actually rise.
    assign hold = (qtr == Q2) && !scl_i;
`else
    logic unused_scl_i;
    assign unused_scl_i = scl_i;
    assign hold         = 1'b0;
`endif

    i2c_qtr_timer #(
        .QTR (QTR)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (state_q == ST_IDLE),
        .hold  (hold),
        .tick  (tick),
        .qtr   (qtr)
    );

    // Next-state logic. The line enables are computed from the *next* state
    // and quarter so that the registered outputs change on the same edge
    // that enters a new quarter.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        wdata_d     = wdata_q;
        rx_d        = rx_q;
        data_read_d = data_read_q;
        bit_cnt_d   = bit_cnt_q;
        ack_err_d   = ack_err_q;
        done_d      = 1'b0;

        qtr_nxt = tick ? i2c_qtr_e'(qtr + 2'd1) : qtr;
        bit_end = tick && (qtr == Q3);
        sample  = tick && (qtr == Q2);

        case (state_q)
            ST_IDLE: begin
                if (start && !busy_q) begin
                    state_d   = ST_START;
                    addr_d    = addr;
                    rw_d      = rw;
                    wdata_d   = data_write;
                    ack_err_d = 1'b0;
                    bit_cnt_d = '0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_ADDR;
                    bit_cnt_d = '0;
                end
            end
            ST_ADDR: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) state_d = ST_ADDR_ACK;
                    else                   bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            ST_ADDR_ACK: begin
                if (sample && sda_i) ack_err_d = 1'b1;
                // ack_err_q already holds this slot's sample by Q3.
                if (bit_end) begin
                    bit_cnt_d = '0;
                    if (ack_err_q) state_d = ST_STOP;
                    else if (rw_q) state_d = ST_READ;
                    else           state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) state_d = ST_WRITE_ACK;
                    else                   bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            ST_WRITE_ACK: begin
                if (sample && sda_i) ack_err_d = 1'b1;
                if (bit_end) state_d = ST_STOP;
            end
            ST_READ: begin
                if (sample) begin
                    rx_d = {rx_q[6:0], sda_i};
                    if (bit_cnt_q == 3'd7) data_read_d = {rx_q[6:0], sda_i};
                end
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) state_d = ST_MNACK;
                    else                   bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            ST_MNACK: begin
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // busy also covers the done cycle, so a start there is ignored.
        busy_d = (state_d != ST_IDLE) || done_d;

        low_half = (qtr_nxt == Q0) || (qtr_nxt == Q1);
        tx_byte  = (state_d == ST_ADDR) ? {addr_d, rw_d} : wdata_d;

        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
        case (state_d)
            ST_START: begin
                sda_oe_d = (qtr_nxt == Q2) || (qtr_nxt == Q3);
            end
            ST_ADDR, ST_WRITE: begin
                scl_oe_d = low_half;
                sda_oe_d = !tx_byte[3'd7 - bit_cnt_d];
            end
            ST_ADDR_ACK, ST_WRITE_ACK, ST_READ, ST_MNACK: begin
                scl_oe_d = low_half;
            end
            ST_STOP: begin
                scl_oe_d = low_half;
                sda_oe_d = (qtr_nxt != Q3);
            end
            default: begin
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            wdata_q     <= '0;
            rx_q        <= '0;
            data_read_q <= '0;
            bit_cnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ack_err_q   <= 1'b0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            wdata_q     <= wdata_d;
            rx_q        <= rx_d;
            data_read_q <= data_read_d;
            bit_cnt_q   <= bit_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ack_err_q   <= ack_err_d;
            scl_oe_q    <= scl_oe_d;
            sda_oe_q    <= sda_oe_d;
        end
    end

    assign data_read = data_read_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ack_err   = ack_err_q;
    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;

endmodule
